ex_muldiv: RTL and testbench

- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register.
- Consumes the control word's M-extension funct3, plus rs1/rs2 operand values after forwarding.
- Holds the pipeline via stall_o while computing, then presents a 32-bit result for one cycle for the EX/MEM register to capture.
- Multiply is radix-2 shift-add; divide is radix-2 restoring. Each takes 32 iterations.

---
 rtl/ex_muldiv.sv | 82 ++++++++
 tb/tb_ex_muldiv.sv | 102 ++++++++++
 2 files changed

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply (shift-add) / divide (restoring) unit that stalls the pipeline while busy
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] rs1_val_i,
  input  logic [WIDTH-1:0] rs2_val_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [2:0]         f3;
  logic [WIDTH-1:0]   m;
  logic [2*WIDTH-1:0] p, p_nx, p_mul, p_div, prod;
  logic               neg;
  logic [5:0]         cnt;
  logic               go, last, s1, s2, n1, n2, neg_in, dz, ovf, fast;
  logic [WIDTH-1:0]   abs1, abs2, fast_res, quo_rem, res;
  logic [WIDTH:0]     sum, r, trial;
  assign go     = state == IDLE && start_i && !flush_i;
  assign last   = cnt == 6'(WIDTH - 1);
  assign s1     = funct3_i[2] ? !funct3_i[0] : (funct3_i == 3'b001 || funct3_i == 3'b010);
  assign s2     = funct3_i[2] ? !funct3_i[0] : funct3_i == 3'b001;
  assign n1     = s1 && rs1_val_i[WIDTH-1];
  assign n2     = s2 && rs2_val_i[WIDTH-1];
  assign abs1   = n1 ? -rs1_val_i : rs1_val_i;
  assign abs2   = n2 ? -rs2_val_i : rs2_val_i;
  assign neg_in = (funct3_i[2] && funct3_i[1]) ? n1 : n1 ^ n2;
  assign dz     = funct3_i[2] && rs2_val_i == '0;
  assign ovf    = funct3_i[2] && !funct3_i[0] && rs1_val_i == {1'b1, {(WIDTH-1){1'b0}}} && rs2_val_i == '1;
  assign fast   = dz || ovf;
  assign fast_res = dz ? (funct3_i[1] ? rs1_val_i : '1) : (funct3_i[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}});
  // p holds {accumulator, multiplier} for multiply and {remainder, dividend/quotient} for divide
  assign sum    = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
  assign p_mul  = {sum, p[WIDTH-1:1]};
  assign r      = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
  assign trial  = r - {1'b0, m};
  assign p_div  = {trial[WIDTH] ? r[WIDTH-1:0] : trial[WIDTH-1:0], p[WIDTH-2:0], !trial[WIDTH]};
  assign p_nx   = f3[2] ? p_div : p_mul;
  assign prod   = neg ? -p_nx : p_nx;
  assign quo_rem = f3[1] ? p_nx[2*WIDTH-1:WIDTH] : p_nx[WIDTH-1:0];
  assign res    = f3[2] ? (neg ? -quo_rem : quo_rem) : (f3 == 3'b000 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
  assign stall_o = !rst && (go || state == CALC);
  assign done_o  = state == DONE;
  always_comb begin
    state_nx = flush_i ? IDLE
             : state == IDLE ? (go ? (fast ? DONE : CALC) : IDLE)
             : state == CALC ? (last ? DONE : CALC)
             : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f3       <= '0;
      m        <= '0;
      p        <= '0;
      neg      <= 1'b0;
      cnt      <= '0;
      result_o <= '0;
    end else if (go) begin
      f3  <= funct3_i;
      m   <= funct3_i[2] ? abs2 : abs1;
      p   <= {{WIDTH{1'b0}}, funct3_i[2] ? abs1 : abs2};
      neg <= neg_in;
      cnt <= '0;
      if (fast) result_o <= fast_res;
    end else if (state == CALC && !flush_i) begin
      p   <= p_nx;
      cnt <= cnt + 6'd1;
      if (last) result_o <= res;
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed-vector check of ex_muldiv results, latency, stall, flush and async reset
module tb_ex_muldiv;
  logic        clk = 0, rst = 1, start = 0, flush = 0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1 = '0, rs2 = '0, result;
  logic        stall, done;
  int errs = 0, checks = 0;
  ex_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start_i(start), .flush_i(flush), .funct3_i(funct3),
    .rs1_val_i(rs1), .rs2_val_i(rs2), .stall_o(stall), .done_o(done), .result_o(result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // lat = cycles from the capture cycle to the done cycle, also the expected number of stalled cycles
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat);
    int n = 0, st = 0;
    @(negedge clk);
    start = 1; funct3 = f; rs1 = a; rs2 = b;
    #1;
    while (!done && n < 100) begin
      if (stall) st++;
      @(posedge clk); #1;
      start = 0;
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(lat));
    chk({tag, " stall cycles"}, 32'(st), 32'(lat));
    chk({tag, " result"}, result, exp);
    @(posedge clk); #1;
    chk({tag, " done pulse"}, {31'b0, done}, 32'd0);
  endtask
  initial begin
    #2;
    chk("reset stall", {31'b0, stall}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    @(negedge clk); rst = 0;
    run_op("MUL 7x6",        3'b000, 32'd7,        32'd6,        32'h0000002A, 33);
    run_op("MUL -3x5",       3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 33);
    run_op("MULH -1x-1",     3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run_op("MULHU",          3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("MULHSU -1x2",    3'b010, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 33);
    run_op("DIV -7/2",       3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("REM -7/2",       3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("DIV 7/-2",       3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 33);
    run_op("REM 7/-2",       3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 33);
    run_op("DIVU 100/7",     3'b101, 32'd100,      32'd7,        32'd14,       33);
    run_op("REMU 100/7",     3'b111, 32'd100,      32'd7,        32'd2,        33);
    run_op("DIVU 5/0",       3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("REM 5/0",        3'b110, 32'd5,        32'd0,        32'd5,        1);
    run_op("DIV ovf",        3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("REM ovf",        3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    // flush at iteration 10 of a divide
    @(negedge clk);
    start = 1; funct3 = 3'b100; rs1 = 32'd1000; rs2 = 32'd3;
    @(posedge clk); #1; start = 0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1;
    #1 chk("flush stall in CALC", {31'b0, stall}, 32'd1);
    @(posedge clk); #1; flush = 0;
    chk("flush stall after", {31'b0, stall}, 32'd0);
    begin
      int seen = 0;
      repeat (40) begin
        if (done) seen++;
        @(posedge clk); #1;
      end
      chk("flush no done", 32'(seen), 32'd0);
    end
    chk("flush result held", result, 32'h00000000);
    run_op("MUL 3x3 after flush", 3'b000, 32'd3, 32'd3, 32'd9, 33);
    // start together with flush in IDLE must not capture
    @(negedge clk);
    start = 1; flush = 1; funct3 = 3'b000; rs1 = 32'd2; rs2 = 32'd2;
    #1 chk("start+flush stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1; start = 0; flush = 0;
    chk("start+flush idle", {31'b0, stall}, 32'd0);
    repeat (2) @(posedge clk);
    #1 chk("start+flush no done", {31'b0, done}, 32'd0);
    // async reset mid-CALC
    @(negedge clk);
    start = 1; funct3 = 3'b000; rs1 = 32'd5; rs2 = 32'd5;
    @(posedge clk); #1; start = 0;
    repeat (5) @(posedge clk);
    #3 rst = 1;
    #1;
    chk("async rst stall", {31'b0, stall}, 32'd0);
    chk("async rst done", {31'b0, done}, 32'd0);
    chk("async rst result", result, 32'd0);
    @(negedge clk); rst = 0;
    run_op("MUL 3x4 after rst", 3'b000, 32'd3, 32'd4, 32'd12, 33);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
